fwd_hazard_unit: RTL

- Control-side counterpart of the EX stage's operand-forwarding muxes: generates the `selOp1`/`selOp2` select codes and load-use stall/bubble controls.
- Tracks destination-register state of the instructions in EX, MEM and WB through its own shadow pipeline registers, advanced in lock-step with the datapath pipeline registers.
- Sits beside the ID/EX boundary of the 5-stage RV32 pipeline.
- Outputs drive the PC and IF/ID enables, the ID/EX bubble insert, and the EX-stage operand select lines.

---
 rtl/fwd_hazard_unit.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard controller for the EX stage of a
// 5-stage RV32 pipeline. Shadows the EX/MEM/WB destination state so the
// operand selects line up with whatever instruction is currently in EX.
module fwd_hazard_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic                   id_useRs1,
  input  logic                   id_useRs2,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   id_regWrite,
  input  logic                   id_memRead,
  input  logic                   flush,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_bubble,
  output logic [1:0]             selOp1,
  output logic [1:0]             selOp2,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  use_rs1;
    logic                  use_rs2;
  } ex_stage_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } back_stage_t;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  ex_stage_t              ex_q, ex_d;
  back_stage_t            mem_q, mem_d;
  back_stage_t            wb_q, wb_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic hazard;
  logic stall;

  // A producer can feed a consumer only if it really writes a non-zero register.
  function automatic logic produces(input back_stage_t st, input logic [REG_ADDR_W-1:0] src);
    return st.valid & st.reg_write & (st.rd != '0) & (st.rd == src);
  endfunction

  // MEM is checked first so the youngest producer wins over WB.
  function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [REG_ADDR_W-1:0] src,
                                         input back_stage_t mem_st, input back_stage_t wb_st);
    logic [1:0] sel;
    sel = SEL_REG;
    if (use_rs) begin
      if (produces(mem_st, src)) begin
        sel = SEL_MEM;
      end else if (produces(wb_st, src)) begin
        sel = SEL_WB;
      end
    end
    return sel;
  endfunction

  // Load-use detection, front-end enables and EX operand selects.
  always_comb begin
    hazard = ex_q.valid & ex_q.mem_read & ex_q.reg_write & (ex_q.rd != '0) & id_valid &
             ((id_useRs1 & (id_rs1 == ex_q.rd)) | (id_useRs2 & (id_rs2 == ex_q.rd)));
    stall       = hazard & ~flush;
    pc_en       = ~stall;
    ifid_en     = ~stall;
    idex_bubble = stall | flush;
    selOp1      = fwd_sel(ex_q.valid & ex_q.use_rs1, ex_q.rs1, mem_q, wb_q);
    selOp2      = fwd_sel(ex_q.valid & ex_q.use_rs2, ex_q.rs2, mem_q, wb_q);
    stall_count = cnt_q;
  end

  // Next shadow-pipeline contents; the back end always advances.
  always_comb begin
    ex_d.valid     = id_valid & ~stall & ~flush;
    ex_d.rd        = id_rd;
    ex_d.reg_write = id_regWrite;
    ex_d.mem_read  = id_memRead;
    ex_d.rs1       = id_rs1;
    ex_d.rs2       = id_rs2;
    ex_d.use_rs1   = id_useRs1;
    ex_d.use_rs2   = id_useRs2;
    mem_d.valid     = ex_q.valid;
    mem_d.rd        = ex_q.rd;
    mem_d.reg_write = ex_q.reg_write;
    wb_d = mem_q;
    cnt_d = cnt_q;
    if (stall && (cnt_q != {STALL_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + STALL_CNT_W'(1);
    end
  end

  // Shadow stage registers and saturating stall counter, cleared on reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
